// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mdu_pkg;

  // Operation codes driven by the E stage.
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } mdu_op_e;

  // Controller states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int CNT_W            = 4;
  localparam int MULT_CYCLES_DEF  = 5;
  localparam int DIV_CYCLES_DEF   = 10;

  // True for the divide operations (the only ones that can hit a zero divisor).
  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit result generator for mult/multu/div/divu.
// Kept separate so it can later be replaced by an iterative divider.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o,
  output logic        div_zero_o
);

  logic        sdiv;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] quo;
  logic [31:0] rem;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Signed division works on magnitudes; 0x80000000 stays 0x80000000 as an
  // unsigned magnitude, so the 0x80000000 / -1 overflow case falls out naturally.
  assign sdiv       = (op_i == OP_DIV);
  assign dvd        = (sdiv && a_i[31]) ? (32'd0 - a_i) : a_i;
  assign dvs        = (sdiv && b_i[31]) ? (32'd0 - b_i) : b_i;
  assign div_zero_o = is_div_op(op_i) && (b_i == 32'd0);

  assign q_u = (b_i == 32'd0) ? 32'd0 : dvd / dvs;
  assign r_u = (b_i == 32'd0) ? 32'd0 : dvd % dvs;

  // Quotient truncates toward zero; remainder takes the dividend's sign.
  assign quo = (sdiv && (a_i[31] ^ b_i[31])) ? (32'd0 - q_u) : q_u;
  assign rem = (sdiv && a_i[31])             ? (32'd0 - r_u) : r_u;

  // Select the result word: {hi, lo}.
  always_comb begin
    res_o = 64'd0;
    case (op_i)
      OP_MULT:          res_o = prod_s;
      OP_MULTU:         res_o = prod_u;
      OP_DIV, OP_DIVU:  res_o = {rem, quo};
      default:          res_o = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: sequences multi-cycle ops with a busy
// down-counter and owns the architectural HI/LO registers.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [63:0]      res;
  logic             div_zero;

  // Result is formed from the latched operands only, so it is stable for the whole run.
  mdu_arith u_arith (
    .op_i       (op_q),
    .a_i        (a_q),
    .b_i        (b_q),
    .res_o      (res),
    .div_zero_o (div_zero)
  );

  // State, counter, operand latches and HI/LO; reset aborts any operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state: accept requests only in IDLE; retire the op when the counter hits zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              op_d    = op;
              a_d     = A;
              b_d     = B;
              cnt_d   = MULT_CNT;
              state_d = ST_RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = op;
              a_d     = A;
              b_d     = B;
              cnt_d   = DIV_CNT;
              state_d = ST_RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // Requests arriving here are dropped; the hazard unit should never send them.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (!div_zero) begin
            hi_d = res[63:32];
            lo_d = res[31:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a_r = '0;
  logic [31:0] b_r = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_mis = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (a_r),
    .B     (b_r),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request for a single cycle; returns #1 after the sampling edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    a_r   = a;
    b_r   = b;
    @(posedge clk); #1;
    start = 1'b0;
    op    = OP_NONE;
  endtask

  // Count remaining busy cycles (bounded) and confirm HI/LO never move while busy.
  task automatic wait_busy(input string tag, input int exp_n);
    int          n;
    logic        moved;
    logic [31:0] h0;
    logic [31:0] l0;
    n     = 0;
    moved = 1'b0;
    h0    = hi;
    l0    = lo;
    while (busy && n < 40) begin
      n++;
      if (hi !== h0 || lo !== l0) moved = 1'b1;
      @(posedge clk); #1;
    end
    check({tag, "_cycles"}, 64'(n), 64'(exp_n));
    check({tag, "_hold"}, 64'(moved), 64'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // MULT -3 * 5
    issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
    wait_busy("mult", 5);
    check("mult_hi", 64'(hi), 64'hFFFFFFFF);
    check("mult_lo", 64'(lo), 64'hFFFFFFF1);

    // MULTU 0xFFFFFFFF * 2
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
    wait_busy("multu", 5);
    check("multu_hi", 64'(hi), 64'h00000001);
    check("multu_lo", 64'(lo), 64'hFFFFFFFE);

    // DIV 7 / -2
    issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
    wait_busy("div", 10);
    check("div_lo", 64'(lo), 64'hFFFFFFFD);
    check("div_hi", 64'(hi), 64'h00000001);

    // DIVU 7 / 0xFFFFFFFE
    issue(OP_DIVU, 32'd7, 32'hFFFFFFFE);
    wait_busy("divu", 10);
    check("divu_lo", 64'(lo), 64'h0);
    check("divu_hi", 64'(hi), 64'h7);

    // Signed overflow case
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_busy("dovf", 10);
    check("dovf_lo", 64'(lo), 64'h80000000);
    check("dovf_hi", 64'(hi), 64'h0);

    // Divide by zero leaves HI/LO untouched
    issue(OP_MTHI, 32'h11111111, 32'd0);
    issue(OP_MTLO, 32'h22222222, 32'd0);
    issue(OP_DIV, 32'd9, 32'd0);
    wait_busy("dz", 10);
    check("dz_hi", 64'(hi), 64'h11111111);
    check("dz_lo", 64'(lo), 64'h22222222);

    // Requests while busy are ignored; back-to-back start accepted
    issue(OP_MULT, 32'd3, 32'd4);
    issue(OP_MTLO, 32'hDEADBEEF, 32'd0);
    check("bz_mtlo_lo", 64'(lo), 64'h22222222);
    check("bz_busy", 64'(busy), 64'd1);
    issue(OP_DIVU, 32'd50, 32'd1);
    wait_busy("bz_mult", 3);
    check("bz_hi", 64'(hi), 64'h0);
    check("bz_lo", 64'(lo), 64'd12);
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_busy("b2b_divu", 10);
    check("b2b_lo", 64'(lo), 64'd14);
    check("b2b_hi", 64'(hi), 64'd2);

    // Asynchronous reset in the third cycle of a DIV
    issue(OP_DIV, 32'd100, 32'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    issue(OP_MULT, 32'd2, 32'd3);
    wait_busy("post_rst", 5);
    check("post_rst_lo", 64'(lo), 64'd6);
    check("post_rst_hi", 64'(hi), 64'd0);

    // MTHI latency: no combinational path, visible after one edge, never busy
    start = 1'b1;
    op    = OP_MTHI;
    a_r   = 32'hCAFEF00D;
    #2;
    check("mthi_pre", 64'(hi), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    op    = OP_NONE;
    check("mthi_hi", 64'(hi), 64'hCAFEF00D);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_lo", 64'(lo), 64'd6);
    @(posedge clk); #1;
    check("mthi_busy2", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Global watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
